// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - aluc operation codes understood by the downstream 32-bit alu
//   - MIPS opcode / funct field constants for the supported subset
//   - dec_t: decoded-instruction struct, plus decode() which builds it
package alu_pkg;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SLL  = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Source of operand b (and, for LUI, forcing a to zero).
  typedef enum logic [1:0] {
    IMM_NONE = 2'd0,  // b = R[rt]
    IMM_SEXT = 2'd1,  // b = sext(imm)
    IMM_ZEXT = 2'd2,  // b = zext(imm)
    IMM_LUI  = 2'd3   // a = 0, b = zext(imm)
  } imm_kind_e;

  typedef struct packed {
    logic [3:0] aluc;
    logic       use_rs;
    logic       use_rt;
    logic       shamt_sel;  // a = shamt field instead of R[rs]
    imm_kind_e  imm_kind;
    logic [4:0] dest;
    logic       legal;
  } dec_t;

  // Illegal words decode to all-zero so they never touch the scoreboard.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    d = '0;
    if (op == OP_RTYPE) begin
      d.use_rs = 1'b1;
      d.use_rt = 1'b1;
      d.dest   = instr[15:11];
      d.legal  = 1'b1;
      case (fn)
        FN_ADD:  d.aluc = ALU_ADD;
        FN_ADDU: d.aluc = ALU_ADDU;
        FN_SUB:  d.aluc = ALU_SUB;
        FN_SUBU: d.aluc = ALU_SUBU;
        FN_AND:  d.aluc = ALU_AND;
        FN_OR:   d.aluc = ALU_OR;
        FN_XOR:  d.aluc = ALU_XOR;
        FN_NOR:  d.aluc = ALU_NOR;
        FN_SLT:  d.aluc = ALU_SLT;
        FN_SLTU: d.aluc = ALU_SLTU;
        FN_SLL:  begin d.aluc = ALU_SLL; d.use_rs = 1'b0; d.shamt_sel = 1'b1; end
        FN_SRL:  begin d.aluc = ALU_SRL; d.use_rs = 1'b0; d.shamt_sel = 1'b1; end
        FN_SRA:  begin d.aluc = ALU_SRA; d.use_rs = 1'b0; d.shamt_sel = 1'b1; end
        FN_SLLV: d.aluc = ALU_SLL;
        FN_SRLV: d.aluc = ALU_SRL;
        FN_SRAV: d.aluc = ALU_SRA;
        default: d.legal = 1'b0;
      endcase
    end else begin
      d.use_rs = 1'b1;
      d.dest   = instr[20:16];
      d.legal  = 1'b1;
      case (op)
        OP_ADDI:  begin d.aluc = ALU_ADD;  d.imm_kind = IMM_SEXT; end
        OP_ADDIU: begin d.aluc = ALU_ADDU; d.imm_kind = IMM_SEXT; end
        OP_SLTI:  begin d.aluc = ALU_SLT;  d.imm_kind = IMM_SEXT; end
        OP_SLTIU: begin d.aluc = ALU_SLTU; d.imm_kind = IMM_SEXT; end
        OP_ANDI:  begin d.aluc = ALU_AND;  d.imm_kind = IMM_ZEXT; end
        OP_ORI:   begin d.aluc = ALU_OR;   d.imm_kind = IMM_ZEXT; end
        OP_XORI:  begin d.aluc = ALU_XOR;  d.imm_kind = IMM_ZEXT; end
        OP_LUI:   begin d.aluc = ALU_LUI;  d.imm_kind = IMM_LUI; d.use_rs = 1'b0; end
        default:  d.legal = 1'b0;
      endcase
    end
    if (!d.legal) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/regfile32.sv
// regfile32: 32 x DATA_W register file.
//   ra0/ra1 -> rdata0/rdata1 : asynchronous read ports with write bypass
//   we/wa/wd                 : synchronous write port
//   $0 is hardwired to zero (never written, always reads 0).
module regfile32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ra0,
  input  logic [4:0]        ra1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [31:0][DATA_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst)                  mem <= '0;
    else if (we && wa != 5'd0) mem[wa] <= wd;
  end

  // A same-cycle write is forwarded so the reader sees the new value.
  always_comb begin
    rdata0 = mem[ra0];
    rdata1 = mem[ra1];
    if (we && wa == ra0) rdata0 = wd;
    if (we && wa == ra1) rdata1 = wd;
    if (ra0 == 5'd0)     rdata0 = '0;
    if (ra1 == 5'd0)     rdata1 = '0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode / operand fetch in front of the 32-bit alu.
//   in_valid/in_ready/instr        : instruction input handshake
//   out_valid/out_ready/a/b/aluc/rd: registered issue output (1-cycle latency)
//   err                            : one-cycle pulse when an unsupported word is consumed
//   wb_en/wb_addr/wb_data          : ALU result writeback (clears the busy bit)
// A busy-bit scoreboard stalls RAW and WAW hazards against in-flight results.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [3:0]        aluc,
  output logic [4:0]        rd,
  output logic              err,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  dec_t              dec;
  logic [4:0]        rs, rt;
  logic [DATA_W-1:0] rs_val, rt_val, a_nxt, b_nxt;
  logic [31:0]       busy, clr_mask, set_mask, busy_eff;
  logic              wb_we, hazard, accept;

  assign dec   = decode(instr);
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign wb_we = wb_en && !rst;

  regfile32 #(.DATA_W(DATA_W)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .ra0    (rs),
    .ra1    (rt),
    .rdata0 (rs_val),
    .rdata1 (rt_val),
    .we     (wb_we),
    .wa     (wb_addr),
    .wd     (wb_data)
  );

  // A busy bit being cleared by this cycle's writeback no longer blocks.
  assign clr_mask = wb_we ? (32'd1 << wb_addr) : 32'd0;
  assign busy_eff = busy & ~clr_mask;

  assign hazard   = dec.legal && ((dec.use_rs && busy_eff[rs]) ||
                                  (dec.use_rt && busy_eff[rt]) ||
                                  busy_eff[dec.dest]);
  assign in_ready = !rst && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  assign set_mask = (accept && dec.legal) ? (32'd1 << dec.dest) : 32'd0;

  always_comb begin
    a_nxt = rs_val;
    if (dec.shamt_sel)               a_nxt = DATA_W'(instr[10:6]);
    else if (dec.imm_kind == IMM_LUI) a_nxt = '0;
    case (dec.imm_kind)
      IMM_SEXT:         b_nxt = {{(DATA_W-16){instr[15]}}, instr[15:0]};
      IMM_ZEXT, IMM_LUI: b_nxt = DATA_W'(instr[15:0]);
      default:          b_nxt = rt_val;
    endcase
  end

  // Set after clear so a same-register set/clear leaves the bit set; $0 never busy.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      aluc      <= '0;
      rd        <= '0;
      err       <= 1'b0;
    end else begin
      err <= accept && !dec.legal;
      if (accept && dec.legal) begin
        out_valid <= 1'b1;
        a         <= a_nxt;
        b         <= b_nxt;
        aluc      <= dec.aluc;
        rd        <= dec.dest;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, err, wb_en;
  logic [31:0] instr, a, b, wb_data;
  logic [3:0]  aluc;
  logic [4:0]  rd, wb_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .a(a), .b(b), .aluc(aluc), .rd(rd),
    .err(err), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mr[32];
  bit          mbusy[32];
  bit          m_valid, m_err;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_aluc;
  logic [4:0]  m_rd;
  logic [36:0] pq[$];   // pending writebacks {addr, data}

  // ak: 0=R[rs] 1=shamt 2=zero ; bk: 0=R[rt] 1=sext 2=zext
  function automatic void mdec(input logic [31:0] w, output bit ok, output logic [3:0] c,
                               output bit urs, output bit urt, output logic [4:0] dst,
                               output int ak, output int bk);
    ok = 1; urs = 1; urt = 1; dst = w[15:11]; ak = 0; bk = 0; c = 4'h0;
    if (w[31:26] == 6'd0) begin
      case (w[5:0])
        6'h20: c = 4'h2;  6'h21: c = 4'h0;  6'h22: c = 4'h3;  6'h23: c = 4'h1;
        6'h24: c = 4'h4;  6'h25: c = 4'h5;  6'h26: c = 4'h6;  6'h27: c = 4'h7;
        6'h2A: c = 4'hB;  6'h2B: c = 4'hA;
        6'h00: begin c = 4'hF; urs = 0; ak = 1; end
        6'h02: begin c = 4'hD; urs = 0; ak = 1; end
        6'h03: begin c = 4'hC; urs = 0; ak = 1; end
        6'h04: c = 4'hF;  6'h06: c = 4'hD;  6'h07: c = 4'hC;
        default: ok = 0;
      endcase
    end else begin
      urt = 0; dst = w[20:16];
      case (w[31:26])
        6'd8:  begin c = 4'h2; bk = 1; end
        6'd9:  begin c = 4'h0; bk = 1; end
        6'd10: begin c = 4'hB; bk = 1; end
        6'd11: begin c = 4'hA; bk = 1; end
        6'd12: begin c = 4'h4; bk = 2; end
        6'd13: begin c = 4'h5; bk = 2; end
        6'd14: begin c = 4'h6; bk = 2; end
        6'd15: begin c = 4'h9; bk = 2; ak = 2; urs = 0; end
        default: ok = 0;
      endcase
    end
  endfunction

  function automatic logic [31:0] mrd(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_en && wb_addr == r) return wb_data;
    return mr[r];
  endfunction

  function automatic bit bz(input logic [4:0] r);
    return mbusy[r] && !(wb_en && wb_addr == r);
  endfunction

  // One clock: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input bit r, input bit iv, input logic [31:0] ins, input bit ordy,
                      input bit we, input logic [4:0] wa, input logic [31:0] wd);
    bit ok, urs, urt, hz, exr, acc;
    logic [3:0] c; logic [4:0] dst; int ak, bk; logic [31:0] ea, eb;
    rst = r; in_valid = iv; instr = ins; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    mdec(ins, ok, c, urs, urt, dst, ak, bk);
    hz  = ok && ((urs && bz(ins[25:21])) || (urt && bz(ins[20:16])) || bz(dst));
    exr = !r && (!m_valid || ordy) && !hz;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exr});
    acc = iv && exr;
    ea  = (ak == 1) ? {27'd0, ins[10:6]} : (ak == 2) ? 32'd0 : mrd(ins[25:21]);
    eb  = (bk == 1) ? {{16{ins[15]}}, ins[15:0]} : (bk == 2) ? {16'd0, ins[15:0]}
                                                             : mrd(ins[20:16]);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin mr[i] = 0; mbusy[i] = 0; end
      m_valid = 0; m_err = 0; m_a = 0; m_b = 0; m_aluc = 0; m_rd = 0;
      pq.delete();
    end else begin
      if (m_valid && ordy && m_rd != 0) pq.push_back({m_rd, 32'($urandom())});
      if (we && wa != 0) begin mr[wa] = wd; mbusy[wa] = 0; end
      m_err = acc && !ok;
      if (acc && ok) begin
        m_valid = 1; m_a = ea; m_b = eb; m_aluc = c; m_rd = dst;
        if (dst != 0) mbusy[dst] = 1;
      end else if (ordy) m_valid = 0;
    end
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("a", a, m_a);
    chk("b", b, m_b);
    chk("aluc", {28'd0, aluc}, {28'd0, m_aluc});
    chk("rd", {27'd0, rd}, {27'd0, m_rd});
  endtask

  logic [5:0] fns[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                          6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

  function automatic logic [31:0] rnd_instr();
    int k;
    logic [4:0] r1, r2, r3;
    k  = $urandom_range(0, 9);
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    r3 = 5'($urandom_range(0, 7));
    if (k <= 4) return {6'd0, r1, r2, r3, 5'($urandom()), fns[$urandom_range(0, 15)]};
    if (k <= 8) return {6'($urandom_range(8, 15)), r1, r2, 16'($urandom())};
    if ($urandom_range(0, 1) == 0) return {6'h3F, 26'($urandom())};
    return {6'd0, r1, r2, r3, 5'd0, 6'b001000};  // jr: unsupported funct
  endfunction

  initial begin
    rst = 1; in_valid = 0; instr = 0; out_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);

    // addiu $1,$0,5
    step(0, 1, 32'h24010005, 1, 0, 0, 0);
    chk("t1_b", b, 32'd5);
    chk("t1_rd", {27'd0, rd}, 32'd1);
    // addu $2,$1,$1 stalls on busy $1, then goes with the writeback
    step(0, 1, 32'h00211021, 1, 0, 0, 0);
    chk("t2_stall_valid", {31'd0, out_valid}, 32'd0);
    step(0, 1, 32'h00211021, 1, 1, 5'd1, 32'd5);
    chk("t2_a", a, 32'd5);
    chk("t2_b", b, 32'd5);
    // R[2] = 0x80000000, then sra $3,$2,8 and lui $4,0x1234
    step(0, 0, 0, 1, 1, 5'd2, 32'h8000_0000);
    step(0, 1, 32'h00021A03, 1, 0, 0, 0);
    chk("sra_a", a, 32'd8);
    chk("sra_b", b, 32'h8000_0000);
    step(0, 1, 32'h3C041234, 1, 0, 0, 0);
    chk("lui_b", b, 32'h0000_1234);
    // slti $5,$1,-1 then backpressure for 3 cycles
    step(0, 1, 32'h2825FFFF, 1, 0, 0, 0);
    chk("slti_b", b, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h24060001, 0, 0, 0, 0);
    chk("hold_aluc", {28'd0, aluc}, 32'hB);
    // unsupported word, then a write to $0
    step(0, 1, 32'hFC000000, 1, 0, 0, 0);
    chk("err_pulse", {31'd0, err}, 32'd1);
    step(0, 0, 0, 1, 1, 5'd0, 32'h0000_DEAD);
    chk("err_clear", {31'd0, err}, 32'd0);
    step(0, 1, 32'h00003821, 1, 0, 0, 0);  // addu $7,$0,$0
    chk("r0_zero", a, 32'd0);
    // reset while stalled with out_valid=1
    step(0, 1, 32'h24080007, 1, 0, 0, 0);  // addiu $8,$0,7
    step(0, 1, 32'h25090001, 0, 0, 0, 0);  // addiu $9,$8,1 stalls
    step(1, 1, 32'h25090001, 0, 0, 0, 0);
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    step(0, 1, 32'h25090001, 1, 0, 0, 0);
    chk("post_rst_issue", {31'd0, out_valid}, 32'd1);

    // randomized traffic
    step(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit r, we; logic [4:0] wa; logic [31:0] wd; logic [36:0] e;
      r  = ($urandom_range(0, 299) == 0);
      we = 0; wa = 5'($urandom()); wd = $urandom();
      if (pq.size() > 0 && $urandom_range(0, 1) == 1) begin
        e = pq.pop_front(); we = 1; wa = e[36:32]; wd = e[31:0];
      end else if ($urandom_range(0, 15) == 0) begin
        we = 1; wa = 0;
      end
      step(r, $urandom_range(0, 3) != 0, rnd_instr(), $urandom_range(0, 3) != 0, we, wa, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/operand-fetch stage directly upstream of the 32-bit `alu`. It accepts MIPS R/I-type ALU instruction words, decodes them into the ALU's `aluc` code and reads operands from an internal 32×32 register file. A busy-bit scoreboard stalls read-after-write and write-after-write hazards. Decoded `a`/`b`/`aluc`/`rd` are presented through one valid/ready output register; the ALU result returns on the writeback port.

## Interface
- `DATA_W`, 32: datapath width; only 32 is supported.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `instr` is valid.
- `in_ready` out 1: stage accepts `instr` this cycle.
- `instr` in 32: MIPS instruction word.
- `out_valid` out 1: `a`/`b`/`aluc`/`rd` are valid.
- `out_ready` in 1: downstream takes the output this cycle.
- `a` out 32: ALU operand a (shift amount for shifts).
- `b` out 32: ALU operand b.
- `aluc` out 4: ALU operation code.
- `rd` out 5: destination register of the issued instruction.
- `err` out 1: one-cycle pulse, unsupported instruction consumed.
- `wb_en` in 1: writeback strobe.
- `wb_addr` in 5: writeback register.
- `wb_data` in 32: writeback value.

## Operation
- **R-type decode** (opcode 000000). Funct→aluc: add 100000→0010, addu 100001→0000, sub 100010→0011, subu 100011→0001, and 100100→0100, or 100101→0101, xor 100110→0110, nor 100111→0111, slt 101010→1011, sltu 101011→1010.
  - R-type operands: a=R[rs], b=R[rt], dest=rd field.
- **Shifts**: sll 000000→1111, srl 000010→1101, sra 000011→1100 with a={27'b0,shamt}. sllv 000100, srlv 000110, srav 000111 use the same codes with a=R[rs]. All shifts: b=R[rt].
- **I-type decode**: addi 001000→0010, addiu 001001→0000, slti 001010→1011, sltiu 001011→1010.
  - Sign-extended imm: b=sext(imm).
  - andi 001100→0100, ori 001101→0101, xori 001110→0110: b=zext(imm).
  - lui 001111→1001: a=0, b=zext(imm); the ALU performs the shift.
  - I-type: a=R[rs], dest=rt.
- **Unsupported words** (any other opcode/funct): consumed when in_ready; `err`=1 next cycle; no output, no scoreboard change.
- **Register file**: R[0] always reads 0; writes to $0 are ignored. `wb_en` writes `wb_data` at the clock edge.
  - Read bypass: if `wb_en` and `wb_addr`==src≠0 in the accept cycle, the operand is `wb_data`.
- **Scoreboard** `busy[31:1]`:
  - Set on accept of a legal instruction with dest≠0.
  - Cleared on `wb_en` for `wb_addr`.
  - Set and clear on the same register in the same cycle: set wins.
- **Hazard**: stall when any used source or the dest is busy and not cleared by `wb_en` this cycle. Unused sources (shamt shifts, lui rs) are not checked.
- **Downstream contract**: exactly one writeback per issued instruction with dest≠0.

## Timing
- `in_ready` = !rst && (!out_valid || out_ready) && !hazard; combinational.
- Accept cycle = `in_valid` && `in_ready`. Outputs are registered; latency is 1 cycle (accept in cycle N → `out_valid` in N+1).
- Output register states:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on `out_ready` with no accept.
  - FULL→FULL on `out_ready` with an accept; new payload is loaded.
- While `out_valid` && !`out_ready`: `a`/`b`/`aluc`/`rd` are held stable.
- Writeback and accept in the same cycle are legal; the bypass supplies the operand and the busy bit clears, so there is no stall.
- **Reset**, including mid-stall or mid-transfer:
  - Outputs: `out_valid`=0, `a`=0, `b`=0, `aluc`=0000, `rd`=0, `err`=0.
  - Internal: all `busy`=0, all registers 0.
  - `wb_en` is ignored while `rst` is high.

## Structure
- Package `alu_pkg`:
  - aluc constants (ALU_ADDU … ALU_SLL).
  - Opcode and funct constants.
  - Decoded-instruction struct {aluc, use_rs, use_rt, shamt_sel, imm_kind, dest, legal}.
- Sub-module `regfile32`: 2 async read ports plus 1 sync write port, $0 hardwired, read bypass built in. The decoder, scoreboard and output register stay in the top module.

## Test plan
- Reset, then `0x24010005` (addiu $1,$0,5) → next cycle `out_valid`=1, `a`=0, `b`=5, `aluc`=0000, `rd`=1; busy[1]=1.
- `0x00211021` (addu $2,$1,$1) with $1 busy → `in_ready`=0. Then `wb_en`, addr 1, data 5 → accepted that cycle; next cycle `a`=`b`=5, `aluc`=0000, `rd`=2.
- With R[2]=0x80000000: `0x00021A03` (sra $3,$2,8) → `a`=8, `b`=0x80000000, `aluc`=1100. `0x3C041234` (lui) → `a`=0, `b`=0x00001234, `aluc`=1001.
- `0x2825FFFF` (slti $5,$1,-1) → `b`=0xFFFFFFFF, `aluc`=1011. Hold `out_ready`=0 for 3 cycles → outputs stable and `in_ready`=0 throughout.
- `0xFC000000` → `err` high exactly 1 cycle, `out_valid` stays 0, busy unchanged. `wb_en` to $0 with 0xDEAD → R[0] still reads 0.
- Assert `rst` while stalled with `out_valid`=1 → next cycle `out_valid`=0 and busy cleared. After reset, a dependent instruction is accepted without waiting for a writeback.
